argo_chan_reader: RTL and testbench

ARGO_CHAN_READER -- requirements
Module: argo_chan_reader

---
 rtl/argo_chan_pkg.sv | 22 ++
 rtl/argo_chan_skid.sv | 45 ++++
 rtl/argo_chan_reader.sv | 119 +++++++++++
 tb/tb_argo_chan_reader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/argo_chan_pkg.sv
// Shared definitions for the ARGO channel reader: occupancy encoding and defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package argo_chan_pkg;

    // Occupancy of the 2-entry prefetch buffer
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    localparam int ARGO_DATA_WIDTH  = 32;
    // Channel FIFO presents read data this many cycles after the pop strobe
    localparam int ARGO_FIFO_RD_LAT = 1;

    // Occupancy as an unsigned level, widened so level + inflight cannot overflow
    function automatic logic [2:0] occ_level(input occ_e s);
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/argo_chan_skid.sv
// Two-entry in-order data store with head/tail select; occupancy is tracked by the caller.
// Latency: write visible on o_head_data the cycle after i_wr when the store was empty.
// Backpressure: none internally; the caller never writes while two entries are held.
module argo_chan_skid
    import argo_chan_pkg::*;
#(
    parameter int DATA_WIDTH = ARGO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_head_data
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_head;
    logic                  r_tail;

    // Write at tail, retire at head; clear rewinds both pointers without touching data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
        end else if (i_clr) begin
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
        end else begin
            if (i_wr) begin
                r_mem[r_tail] <= i_wr_data;
                r_tail        <= ~r_tail;
            end
            if (i_rd) begin
                r_head <= ~r_head;
            end
        end
    end

    assign o_head_data = r_mem[r_head];

endmodule

// File: rtl/argo_chan_reader.sv
// Channel reader: prefetches from a 1-cycle-latency FIFO into a 2-entry buffer and presents items in order.
// Latency: item issued at t, captured at t+1, recv_valid at t+2; one item per cycle in steady state.
// Backpressure: recv_ready low stalls the head; issue stops once buffered + in-flight items reach 2.
// Optional ARGO_CHAN_TRACE_EN adds a cycle counter and trace prints for issue/arrival/pop/flush.
module argo_chan_reader
    import argo_chan_pkg::*;
#(
    parameter int DATA_WIDTH = ARGO_DATA_WIDTH,
    parameter int CHAN_ID    = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush,
    output logic                  recv_valid,
    input  logic                  recv_ready,
    output logic [DATA_WIDTH-1:0] recv_data,
    output logic [31:0]           recv_count
);

    occ_e        r_state;
    logic        r_inflight;
    logic        r_run;
    logic [31:0] r_count;

    logic        w_pop;
    logic        w_arrive;
    logic [2:0]  w_level;
    logic        w_issue;

    // A pop during flush is not a transfer: the buffer is being discarded
    assign w_pop    = (r_state != OCC_EMPTY) && recv_ready && !flush;
    assign w_arrive = r_inflight && !flush;
    assign w_level  = occ_level(r_state) + {2'b00, r_inflight} - {2'b00, w_pop};
    // r_run holds off issue until the first edge after reset release
    assign w_issue  = r_run && !fifo_empty && !flush && (w_level < 3'd2);

    assign fifo_rd_en = w_issue;
    assign recv_valid = (r_state != OCC_EMPTY);

    // Occupancy FSM; simultaneous arrival and pop leave the level unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= OCC_EMPTY;
        end else if (flush) begin
            r_state <= OCC_EMPTY;
        end else begin
            case (r_state)
                OCC_EMPTY: if (w_arrive) r_state <= OCC_ONE;
                OCC_ONE: begin
                    if (w_arrive && !w_pop)      r_state <= OCC_TWO;
                    else if (!w_arrive && w_pop) r_state <= OCC_EMPTY;
                end
                OCC_TWO:   if (w_pop && !w_arrive) r_state <= OCC_ONE;
                default:   r_state <= OCC_EMPTY;
            endcase
        end
    end

    // In-flight flag mirrors last cycle's issue; run enable rises one edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= 1'b0;
            r_run      <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_run      <= 1'b1;
        end
    end

    // Delivered-item counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_pop) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign recv_count = r_count;

    argo_chan_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (flush),
        .i_wr        (w_arrive),
        .i_wr_data   (fifo_rd_data),
        .i_rd        (w_pop),
        .o_head_data (recv_data)
    );

`ifdef ARGO_CHAN_TRACE_EN
    logic [31:0] r_cycle;

    // Free-running cycle stamp for trace lines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // Trace each channel event as it is committed at the clock edge
    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_issue)  $display("[%0d] chan %0d issue", r_cycle, CHAN_ID);
            if (w_arrive) $display("[%0d] chan %0d arrive %0h", r_cycle, CHAN_ID, fifo_rd_data);
            if (w_pop)    $display("[%0d] chan %0d pop %0h", r_cycle, CHAN_ID, recv_data);
            if (flush)    $display("[%0d] chan %0d flush", r_cycle, CHAN_ID);
        end
    end
`endif

endmodule

// File: tb/tb_argo_chan_reader.sv
// Self-checking bench for argo_chan_reader: behavioural FIFO plus in-order scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Model: items leave the FIFO on each observed pop strobe and must reappear in the same order.
module tb_argo_chan_reader;

    localparam int DW = 32;

    logic          clk          = 1'b0;
    logic          rst          = 1'b0;
    logic          fifo_empty   = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          flush        = 1'b0;
    logic          recv_valid;
    logic          recv_ready   = 1'b0;
    logic [DW-1:0] recv_data;
    logic [31:0]   recv_count;

    int checks = 0;
    int errors = 0;

    // Behavioural FIFO contents and items taken from it but not yet delivered
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] sent_q [$];

    logic          obs_rd_en, obs_valid, obs_pop, obs_empty, obs_flush;
    logic [DW-1:0] obs_data;
    logic [31:0]   obs_count;

    always #5 clk = ~clk;

    argo_chan_reader #(
        .DATA_WIDTH (DW),
        .CHAN_ID    (7)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .recv_valid   (recv_valid),
        .recv_ready   (recv_ready),
        .recv_data    (recv_data),
        .recv_count   (recv_count)
    );

    task automatic fifo_push(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample outputs at negedge, then let the FIFO answer a pop strobe after the edge
    task automatic step();
        @(negedge clk);
        obs_rd_en = fifo_rd_en;
        obs_valid = recv_valid;
        obs_data  = recv_data;
        obs_count = recv_count;
        obs_empty = fifo_empty;
        obs_flush = flush;
        obs_pop   = recv_valid && recv_ready;
        @(posedge clk);
        #1;
        if (obs_flush) sent_q.delete();
        if (obs_rd_en && fifo_q.size() > 0) begin
            fifo_rd_data = fifo_q.pop_front();
            sent_q.push_back(fifo_rd_data);
        end else begin
            fifo_rd_data = $urandom;
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic test_reset();
        int got;
        logic [DW-1:0] dummy;
        fifo_push(32'h55);
        repeat (3) @(posedge clk);
        #2;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", recv_valid); end
        checks++; if (recv_data !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", recv_data); end
        checks++; if (recv_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", recv_count); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        checks++; if (obs_rd_en !== 1'b0) begin errors++; $display("FAIL first_cycle_no_issue: got %b want 0", obs_rd_en); end
        step();
        checks++; if (obs_rd_en !== 1'b1) begin errors++; $display("FAIL issue_after_release: got %b want 1", obs_rd_en); end
        recv_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (obs_pop) begin
                got++;
                if (sent_q.size() > 0) dummy = sent_q.pop_front();
                checks++; if (obs_data !== 32'h55) begin errors++; $display("FAIL reset_first_item: got %0h want 55", obs_data); end
            end
        end
        checks++; if (got != 1) begin errors++; $display("FAIL reset_item_count: got %0d want 1", got); end
        checks++; if (recv_count !== 32'd1) begin errors++; $display("FAIL reset_recv_count: got %0d want 1", recv_count); end
        recv_ready = 1'b0;
    endtask

    task automatic test_latency();
        logic [DW-1:0] want [3];
        logic [DW-1:0] dummy;
        int pc [3];
        int n, issue_c, valid_c;
        logic [31:0] base;
        want[0] = 32'hA; want[1] = 32'hB; want[2] = 32'hC;
        base = recv_count;
        recv_ready = 1'b1;
        for (int i = 0; i < 3; i++) fifo_push(want[i]);
        n = 0; issue_c = -1; valid_c = -1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (obs_rd_en && issue_c < 0) issue_c = c;
            if (obs_valid && valid_c < 0) valid_c = c;
            if (obs_pop) begin
                if (sent_q.size() > 0) dummy = sent_q.pop_front();
                if (n < 3) begin
                    pc[n] = c;
                    checks++; if (obs_data !== want[n]) begin errors++; $display("FAIL latency_data%0d: got %0h want %0h", n, obs_data, want[n]); end
                end
                n++;
            end
        end
        checks++; if (issue_c != 0) begin errors++; $display("FAIL latency_issue_cycle: got %0d want 0", issue_c); end
        checks++; if (valid_c != issue_c + 2) begin errors++; $display("FAIL latency_valid_cycle: got %0d want %0d", valid_c, issue_c + 2); end
        checks++; if (n != 3 || pc[2] - pc[0] != 2) begin errors++; $display("FAIL latency_back_to_back: got %0d items span %0d want 3 span 2", n, (n == 3) ? pc[2] - pc[0] : -1); end
        checks++; if (recv_count !== base + 32'd3) begin errors++; $display("FAIL latency_count: got %0d want %0d", recv_count, base + 32'd3); end
        recv_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [DW-1:0] it [5];
        logic [DW-1:0] dummy;
        int pulses, k;
        logic [31:0] base;
        base = recv_count;
        recv_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin it[i] = $urandom; fifo_push(it[i]); end
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (obs_rd_en) pulses++;
            if (c >= 2) begin
                checks++; if (obs_valid !== 1'b1 || obs_data !== it[0]) begin errors++; $display("FAIL stall_hold c%0d: got v=%b %0h want v=1 %0h", c, obs_valid, obs_data, it[0]); end
            end
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL stall_pulses: got %0d want 2", pulses); end
        recv_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (obs_pop) begin
                if (sent_q.size() > 0) dummy = sent_q.pop_front();
                checks++; if (k >= 5 || obs_data !== it[k]) begin errors++; $display("FAIL stall_drain%0d: got %0h want %0h", k, obs_data, (k < 5) ? it[k] : '0); end
                k++;
            end
        end
        checks++; if (k != 5) begin errors++; $display("FAIL stall_drain_count: got %0d want 5", k); end
        checks++; if (recv_count !== base + 32'd5) begin errors++; $display("FAIL stall_recv_count: got %0d want %0d", recv_count, base + 32'd5); end
        recv_ready = 1'b0;
    endtask

    task automatic test_empty();
        int bad;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            recv_ready = $urandom_range(0, 1);
            step();
            if (obs_rd_en !== 1'b0 || obs_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL empty_idle: got %0d active cycles want 0", bad); end
        recv_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [DW-1:0] it [4];
        logic [DW-1:0] dummy, exp;
        int pulses, k;
        logic [31:0] base;
        base = recv_count;
        recv_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin it[i] = $urandom; fifo_push(it[i]); end
        pulses = 0;
        for (int c = 0; c < 10 && pulses < 2; c++) begin
            step();
            if (obs_rd_en) pulses++;
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL flush_setup_pulses: got %0d want 2", pulses); end
        flush = 1'b1;
        step();
        checks++; if (obs_rd_en !== 1'b0) begin errors++; $display("FAIL flush_rd_en: got %b want 0", obs_rd_en); end
        flush = 1'b0;
        step();
        checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", obs_valid); end
        checks++; if (obs_count !== base) begin errors++; $display("FAIL flush_count: got %0d want %0d", obs_count, base); end
        recv_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (obs_pop) begin
                exp = (sent_q.size() > 0) ? sent_q[0] : '0;
                if (sent_q.size() > 0) dummy = sent_q.pop_front();
                checks++; if (obs_data !== exp || obs_data === it[0] || obs_data === it[1]) begin errors++; $display("FAIL flush_after%0d: got %0h want %0h", k, obs_data, exp); end
                k++;
            end
        end
        checks++; if (k != 2) begin errors++; $display("FAIL flush_after_count: got %0d want 2", k); end
        recv_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] it [4];
        logic [DW-1:0] dummy;
        int k;
        recv_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin it[i] = $urandom; fifo_push(it[i]); end
        repeat (4) step();
        #2;
        rst = 1'b0;
        #1;
        checks++; if (fifo_rd_en !== 1'b0 || recv_valid !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got rd=%b v=%b want 0 0", fifo_rd_en, recv_valid); end
        checks++; if (recv_data !== '0 || recv_count !== 32'd0) begin errors++; $display("FAIL midreset_data: got %0h cnt %0d want 0 0", recv_data, recv_count); end
        sent_q.delete();
        step();
        step();
        rst = 1'b1;
        recv_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (obs_pop) begin
                if (sent_q.size() > 0) dummy = sent_q.pop_front();
                checks++; if (k >= 2 || obs_data !== it[k + 2]) begin errors++; $display("FAIL midreset_item%0d: got %0h want %0h", k, obs_data, (k < 2) ? it[k + 2] : '0); end
                k++;
            end
        end
        checks++; if (k != 2 || recv_count !== 32'd2) begin errors++; $display("FAIL midreset_count: got %0d items cnt %0d want 2 2", k, recv_count); end
        recv_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] in_q [$];
        logic [DW-1:0] d, exp, dummy, stall_data;
        logic stall_prev;
        int pushed, popped, bad_issue, bad_occ;
        logic [31:0] base;
        base = recv_count;
        pushed = 0; popped = 0; bad_issue = 0; bad_occ = 0;
        stall_prev = 1'b0; stall_data = '0;
        for (int cyc = 0; cyc < 20000 && popped < 1000; cyc++) begin
            if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
                d = $urandom;
                fifo_push(d);
                in_q.push_back(d);
                pushed++;
            end
            recv_ready = ($urandom_range(0, 3) != 0);
            step();
            if (obs_rd_en && obs_empty) bad_issue++;
            if (stall_prev) begin
                checks++; if (obs_valid !== 1'b1 || obs_data !== stall_data) begin errors++; $display("FAIL random_stall_hold: got v=%b %0h want v=1 %0h", obs_valid, obs_data, stall_data); end
            end
            if (obs_pop) begin
                exp = (in_q.size() > 0) ? in_q[0] : '0;
                if (in_q.size() > 0) dummy = in_q.pop_front();
                if (sent_q.size() > 0) dummy = sent_q.pop_front();
                checks++; if (obs_data !== exp) begin errors++; $display("FAIL random_order item %0d: got %0h want %0h", popped, obs_data, exp); end
                popped++;
            end
            if (sent_q.size() > 2) bad_occ++;
            stall_prev = obs_valid && !obs_pop;
            stall_data = obs_data;
        end
        checks++; if (popped != 1000) begin errors++; $display("FAIL random_delivered: got %0d want 1000", popped); end
        checks++; if (recv_count !== base + 32'd1000) begin errors++; $display("FAIL random_count: got %0d want %0d", recv_count, base + 32'd1000); end
        checks++; if (bad_issue != 0) begin errors++; $display("FAIL random_issue_on_empty: got %0d want 0", bad_issue); end
        checks++; if (bad_occ != 0) begin errors++; $display("FAIL random_overflow: got %0d want 0", bad_occ); end
        recv_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_empty();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
